// File: rtl/spi_bridge_pkg.sv
// Shared types and field positions for the SPI register bridge.
// Packet and response share one 2/14/24-bit layout.
package spi_bridge_pkg;

  typedef enum logic [1:0] {
    OP_NOP    = 2'b00,
    OP_READ   = 2'b01,
    OP_WRITE  = 2'b10,
    OP_STATUS = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_OK    = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10,
    ST_ERR   = 2'b11
  } status_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_RESPOND
  } state_t;

  localparam int OP_HI   = 39;
  localparam int OP_LO   = 38;
  localparam int ADDR_HI = 37;
  localparam int ADDR_LO = 24;
  localparam int DATA_HI = 23;
  localparam int DATA_LO = 0;
  localparam int CNT_W   = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear.
// Clear together with increment leaves the count at one.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= inc ? WIDTH'(1) : '0;
    end else if (inc && count != '1) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/spi_reg_bridge.sv
// Decodes SPI packets into memory req/ack accesses and loads
// the response for the serializer to shift out next packet.
module spi_reg_bridge
  import spi_bridge_pkg::*;
#(
  parameter int PACKET_WIDTH   = 40,
  parameter int ADDR_WIDTH     = 14,
  parameter int DATA_WIDTH     = 24,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [PACKET_WIDTH-1:0] rxPacket,
  input  logic                    dataReady,
  output logic [PACKET_WIDTH-1:0] txData,
  output logic                    load,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    mem_ack
);

  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

  state_t            state, state_nxt;
  op_t               op_q, pkt_op;
  logic [13:0]       addr_q, pkt_addr;
  logic [23:0]       pkt_data;
  logic [TW-1:0]     timer;
  logic [PACKET_WIDTH-1:0] resp;
  logic              issue, addr_bad, tmo_last;
  logic              tmo_inc, drop_inc, stat_clr;
  logic [CNT_W-1:0]  drop_cnt, tmo_cnt;

  assign pkt_op   = op_t'(rxPacket[OP_HI:OP_LO]);
  assign pkt_addr = rxPacket[ADDR_HI:ADDR_LO];
  assign pkt_data = rxPacket[DATA_HI:DATA_LO];
  assign addr_bad = (pkt_addr >> ADDR_WIDTH) != '0;
  assign tmo_last = timer == TW'(TIMEOUT_CYCLES - 1);

  assign mem_req  = state == S_ISSUE;
  assign load     = state == S_RESPOND;
  assign drop_inc = dataReady && state != S_IDLE;
  assign stat_clr = load && op_q == OP_STATUS;

  always_comb begin
    state_nxt = state;
    resp      = txData;
    issue     = 1'b0;
    tmo_inc   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (dataReady) begin
          unique case (pkt_op)
            OP_READ, OP_WRITE: begin
              if (addr_bad) begin
                state_nxt = S_RESPOND;
                resp = {ST_ERR, pkt_addr, 24'h0};
              end else begin
                state_nxt = S_ISSUE;
                issue = 1'b1;
              end
            end
            OP_STATUS: begin
              state_nxt = S_RESPOND;
              resp = {ST_OK, pkt_addr,
                      8'h00, drop_cnt, tmo_cnt};
            end
            default: begin
              state_nxt = S_RESPOND;
              resp = {ST_OK, pkt_addr, 24'h0};
            end
          endcase
        end
      end
      S_ISSUE: begin
        if (mem_ack) begin
          state_nxt = S_RESPOND;
          if (op_q == OP_READ)
            resp = {ST_READ, addr_q, mem_rdata};
          else
            resp = {ST_WRITE, addr_q, 24'h0};
        end else if (tmo_last) begin
          state_nxt = S_RESPOND;
          tmo_inc = 1'b1;
          resp = {ST_ERR, addr_q, 24'h0};
        end
      end
      S_RESPOND: state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      op_q      <= OP_NOP;
      addr_q    <= '0;
      timer     <= '0;
      txData    <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state  <= state_nxt;
      txData <= resp;
      if (state == S_IDLE && dataReady) begin
        op_q   <= pkt_op;
        addr_q <= pkt_addr;
      end
      if (issue) begin
        timer     <= '0;
        mem_we    <= pkt_op == OP_WRITE;
        mem_addr  <= pkt_addr[ADDR_WIDTH-1:0];
        mem_wdata <= pkt_data;
      end else if (state == S_ISSUE) begin
        timer <= timer + 1'b1;
      end
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_drop_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (drop_inc),
    .clr   (stat_clr),
    .count (drop_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_tmo_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (tmo_inc),
    .clr   (stat_clr),
    .count (tmo_cnt)
  );

endmodule
